// File: rtl/scatter_a_unit_pkg.sv
// Shared constants and types for the A-operand scatter unit.
// Holds the default geometry of the A/B matrices, the constants derived
// from it, and the state encoding of the stripe sequencer.
package scatter_a_unit_pkg;

  localparam int W             = 8;
  localparam int N             = 16;
  localparam int BRAM_W        = 128;
  localparam int BRAM_AW       = 9;
  localparam int DATA_A_SIZE_X = 64;
  localparam int DATA_A_SIZE_Y = 64;
  localparam int DATA_B_SIZE_X = 64;
  localparam int DATA_B_SIZE_Y = 64;

  localparam int STRIPES  = DATA_A_SIZE_Y / N;
  localparam int SKEW_LAT = N - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/scatter_a_unit_skew_delay_line.sv
// Fixed-depth shift register carrying one lane's data plus its valid flag.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   in_data, in_valid  lane input
//   out_data, out_valid lane input delayed by DEPTH cycles (DEPTH=0 is a wire)
module skew_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_data  = in_data;
      assign out_valid = in_valid;
    end else begin : g_shift
      logic [W-1:0] data_reg  [DEPTH];
      logic         valid_reg [DEPTH];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < DEPTH; s++) begin
            data_reg[s]  <= '0;
            valid_reg[s] <= 1'b0;
          end
        end else begin
          data_reg[0]  <= in_data;
          valid_reg[0] <= in_valid;
          for (int s = 1; s < DEPTH; s++) begin
            data_reg[s]  <= data_reg[s-1];
            valid_reg[s] <= valid_reg[s-1];
          end
        end
      end

      assign out_data  = data_reg[DEPTH-1];
      assign out_valid = valid_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/scatter_a_unit.sv
// Streams one N-row stripe of matrix A from a block RAM into the row inputs
// of a systolic array, one K column per cycle, with lane i delayed i cycles.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start_cal       start request (rising edge, ignored while busy)
//   bram_*_a        BRAM port (read only: we=0, wrdata=0, 1-cycle read latency)
//   a_in            skewed row operands, 0 on lanes without valid data
//   col_cal_done    one-cycle pulse once the last skewed element has left
module scatter_a_unit
  import scatter_a_unit_pkg::*;
#(
  parameter int W_P             = W,
  parameter int N_P             = N,
  parameter int BRAM_W_P        = BRAM_W,
  parameter int BRAM_AW_P       = BRAM_AW,
  parameter int DATA_A_SIZE_X_P = DATA_A_SIZE_X,
  parameter int DATA_A_SIZE_Y_P = DATA_A_SIZE_Y,
  parameter int DATA_B_SIZE_X_P = DATA_B_SIZE_X,
  parameter int DATA_B_SIZE_Y_P = DATA_B_SIZE_Y
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_cal,
  output logic                      bram_clk_a,
  output logic                      bram_we_a,
  output logic [BRAM_AW_P-1:0]      bram_addr_a,
  output logic [BRAM_W_P-1:0]       bram_wrdata_a,
  input  logic [BRAM_W_P-1:0]       bram_rddata_a,
  output logic [N_P-1:0][W_P-1:0]   a_in,
  output logic                      col_cal_done
);

  localparam int STRIPES_P  = DATA_A_SIZE_Y_P / N_P;
  localparam int SKEW_LAT_P = N_P - 1;
  // Counter serves both the K walk and the drain wait.
  localparam int CNT_MAX    = (DATA_A_SIZE_X_P > SKEW_LAT_P + 1) ? DATA_A_SIZE_X_P : SKEW_LAT_P + 2;
  localparam int CNT_W      = $clog2(CNT_MAX);
  localparam int STRIPE_W   = (STRIPES_P > 1) ? $clog2(STRIPES_P) : 1;

  generate
    if (BRAM_W_P != N_P * W_P) begin : g_chk_bw
      $error("BRAM_W must equal N*W");
    end
    if (DATA_B_SIZE_Y_P != DATA_A_SIZE_X_P) begin : g_chk_k
      $error("DATA_B_SIZE_Y must equal DATA_A_SIZE_X");
    end
    if ((DATA_A_SIZE_Y_P % N_P) != 0) begin : g_chk_y
      $error("DATA_A_SIZE_Y must be a multiple of N");
    end
    if (DATA_A_SIZE_Y_P * DATA_A_SIZE_X_P / N_P > (1 << BRAM_AW_P)) begin : g_chk_aw
      $error("A matrix does not fit the BRAM address space");
    end
    if (DATA_B_SIZE_X_P < 1) begin : g_chk_bx
      $error("DATA_B_SIZE_X must be positive");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    k_reg, k_next;
  logic [STRIPE_W-1:0] stripe_reg, stripe_next;
  logic                start_prev_reg;
  logic                rd_valid_reg;
  logic                done;
  logic [BRAM_AW_P-1:0] base;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      k_reg          <= '0;
      stripe_reg     <= '0;
      start_prev_reg <= 1'b0;
      rd_valid_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      k_reg          <= k_next;
      stripe_reg     <= stripe_next;
      start_prev_reg <= start_cal;
      // Read data arrives one cycle after the address was issued.
      rd_valid_reg   <= (state_reg == READ);
    end
  end

  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    stripe_next = stripe_reg;
    done        = 1'b0;
    case (state_reg)
      IDLE: begin
        k_next = '0;
        if (start_cal && !start_prev_reg) state_next = READ;
      end
      READ: begin
        if (k_reg == CNT_W'(DATA_A_SIZE_X_P - 1)) begin
          state_next = DRAIN;
          k_next     = '0;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      DRAIN: begin
        // Drain covers the read latency plus the deepest skew lane.
        if (k_reg == CNT_W'(SKEW_LAT_P + 1)) begin
          done       = 1'b1;
          state_next = IDLE;
          k_next     = '0;
          stripe_next = (stripe_reg == STRIPE_W'(STRIPES_P - 1)) ? '0 : stripe_reg + 1'b1;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        k_next     = '0;
      end
    endcase
  end

  assign base          = BRAM_AW_P'(stripe_reg) * BRAM_AW_P'(DATA_A_SIZE_X_P);
  assign bram_addr_a   = (state_reg == READ) ? base + BRAM_AW_P'(k_reg) : base;
  assign bram_clk_a    = clk;
  assign bram_we_a     = 1'b0;
  assign bram_wrdata_a = '0;
  assign col_cal_done  = done;

  genvar gi;
  generate
    for (gi = 0; gi < N_P; gi++) begin : g_lane
      logic [W_P-1:0] lane_data;
      logic           lane_valid;

      skew_delay_line #(
        .W     (W_P),
        .DEPTH (gi)
      ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_data   (bram_rddata_a[W_P*gi +: W_P]),
        .in_valid  (rd_valid_reg),
        .out_data  (lane_data),
        .out_valid (lane_valid)
      );

      assign a_in[gi] = lane_valid ? lane_data : '0;
    end
  endgenerate

endmodule

// File: tb/tb_scatter_a_unit.sv
module tb_scatter_a_unit;

  logic              clk;
  logic              rst;
  logic              start_cal;
  logic              bram_clk_a;
  logic              bram_we_a;
  logic [8:0]        bram_addr_a;
  logic [127:0]      bram_wrdata_a;
  logic [127:0]      bram_rddata_a;
  logic [15:0][7:0]  a_in;
  logic              col_cal_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] mem [0:511];

  scatter_a_unit dut (
    .clk           (clk),
    .rst           (rst),
    .start_cal     (start_cal),
    .bram_clk_a    (bram_clk_a),
    .bram_we_a     (bram_we_a),
    .bram_addr_a   (bram_addr_a),
    .bram_wrdata_a (bram_wrdata_a),
    .bram_rddata_a (bram_rddata_a),
    .a_in          (a_in),
    .col_cal_done  (col_cal_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model with one cycle of read latency.
  always @(posedge clk) bram_rddata_a <= mem[bram_addr_a];

  // sel 0: byte i of word a = (i*64 + a) & 0xFF   (stripe 0 matches (i*64+k))
  // sel 1: every byte of word a = (a % 64) + 1
  task automatic fill_mem(input int sel);
    for (int a = 0; a < 512; a++) begin
      logic [127:0] w;
      for (int i = 0; i < 16; i++) begin
        if (sel == 0) w[8*i +: 8] = 8'((i*64 + a) & 8'hFF);
        else          w[8*i +: 8] = 8'((a % 64) + 1);
      end
      mem[a] = w;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    start_cal = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Runs one stripe and checks every cycle: address, lanes, done pulse.
  // busy_at/abort_at < 0 disable the busy pulse / mid-stream reset.
  task automatic run_stripe(input int exp_base, input int hold, input int busy_at,
                            input int abort_at);
    int next_base;
    int n_done;
    next_base = (exp_base + 64) % 256;
    n_done = 0;
    @(negedge clk);
    start_cal = 1'b1;
    for (int j = 0; j <= 90; j++) begin
      logic [15:0][7:0] exp_a;
      @(posedge clk);
      @(negedge clk);
      if (j == hold) start_cal = 1'b0;
      if (busy_at >= 0 && j == busy_at) start_cal = 1'b1;
      if (busy_at >= 0 && j == busy_at + 1) start_cal = 1'b0;
      if (abort_at >= 0 && j == abort_at) begin
        rst = 1'b0;
        #1;
        n_checks++;
        if (a_in !== '0 || col_cal_done !== 1'b0 || bram_addr_a !== 9'd0) begin
          n_fail++;
          $display("FAIL abort_immediate: a_in=%h done=%b addr=%0d required 0/0/0",
                   a_in, col_cal_done, bram_addr_a);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 90; c++) begin
          @(negedge clk);
          n_checks++;
          if (col_cal_done !== 1'b0 || a_in !== '0 || bram_addr_a !== 9'd0) begin
            n_fail++;
            $display("FAIL abort_idle c=%0d: done=%b a_in=%h addr=%0d required 0/0/0",
                     c, col_cal_done, a_in, bram_addr_a);
          end
        end
        $display("stripe base=%0d aborted at T0+%0d", exp_base, abort_at);
        return;
      end
      for (int i = 0; i < 16; i++) begin
        int k;
        logic [127:0] w;
        k = j - 1 - i;
        exp_a[i] = 8'h00;
        if (k >= 0 && k < 64) begin
          w = mem[exp_base + k];
          exp_a[i] = w[8*i +: 8];
        end
      end
      n_checks++;
      if (a_in !== exp_a) begin
        n_fail++;
        $display("FAIL a_in T0+%0d: got %h required %h", j, a_in, exp_a);
      end
      n_checks++;
      if (col_cal_done !== (j == 80)) begin
        n_fail++;
        $display("FAIL done T0+%0d: got %b required %b", j, col_cal_done, (j == 80));
      end
      if (col_cal_done === 1'b1) n_done++;
      if (j < 64) begin
        n_checks++;
        if (bram_addr_a !== 9'(exp_base + j)) begin
          n_fail++;
          $display("FAIL addr T0+%0d: got %0d required %0d", j, bram_addr_a, exp_base + j);
        end
      end else if (j > 80) begin
        n_checks++;
        if (bram_addr_a !== 9'(next_base)) begin
          n_fail++;
          $display("FAIL idle_addr T0+%0d: got %0d required %0d", j, bram_addr_a, next_base);
        end
      end
    end
    $display("stripe base=%0d done_pulses=%0d", exp_base, n_done);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_cal = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (a_in !== '0 || col_cal_done !== 1'b0 || bram_addr_a !== 9'd0 ||
          bram_we_a !== 1'b0 || bram_wrdata_a !== '0) begin
        n_fail++;
        $display("FAIL reset c=%0d: a_in=%h done=%b addr=%0d we=%b required 0",
                 c, a_in, col_cal_done, bram_addr_a, bram_we_a);
      end
    end
    $display("test_reset complete");
  endtask

  task automatic test_single_stripe();
    fill_mem(0);
    run_stripe(0, 10, -1, -1);
  endtask

  task automatic test_busy_start();
    run_stripe(64, 3, 62, -1);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_checks++;
      if (col_cal_done !== 1'b0 || bram_addr_a !== 9'd128) begin
        n_fail++;
        $display("FAIL busy_ignored c=%0d: done=%b addr=%0d required 0/128",
                 c, col_cal_done, bram_addr_a);
      end
    end
    $display("test_busy_start complete");
  endtask

  task automatic test_wrap();
    reset_dut();
    run_stripe(0, 2, -1, -1);
    run_stripe(64, 2, -1, -1);
    run_stripe(128, 2, -1, -1);
    run_stripe(192, 2, -1, -1);
    run_stripe(0, 2, -1, -1);
  endtask

  task automatic test_reset_mid();
    run_stripe(64, 2, -1, 30);
    run_stripe(0, 2, -1, -1);
  endtask

  task automatic test_skew();
    int waited;
    fill_mem(1);
    @(negedge clk);
    start_cal = 1'b1;
    repeat (17) begin
      @(posedge clk);
      @(negedge clk);
    end
    start_cal = 1'b0;
    // Now at T0+16: lane i holds word 15-i whose bytes are 16-i.
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (a_in[i] !== 8'(16 - i)) begin
        n_fail++;
        $display("FAIL skew lane %0d: got %0d required %0d", i, a_in[i], 16 - i);
      end
    end
    waited = 16;
    while (col_cal_done !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited != 80) begin
      n_fail++;
      $display("FAIL skew_done_time: got T0+%0d required T0+80", waited);
    end
    $display("test_skew complete, done at T0+%0d", waited);
  endtask

  initial begin
    rst = 1'b0;
    start_cal = 1'b0;
    fill_mem(0);
    test_reset();
    test_single_stripe();
    test_busy_start();
    test_wrap();
    test_reset_mid();
    test_skew();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
